// File: rtl/ahb2apb.sv
// AHB-Lite slave to APB4 master bridge.
// Each accepted AHB transfer becomes one APB setup/access pair. The bridge
// handles one transfer at a time. Read data and errors go back to the AHB
// master. AHB and APB share a single clock.
module ahb2apb #(
    parameter int ADDR_BITS = 32
) (
    input  logic                 ahb_clock,
    input  logic                 reset,
    input  logic                 ahb_hsel,
    input  logic [1:0]           ahb_htrans,
    input  logic                 ahb_hwrite,
    input  logic [ADDR_BITS-1:0] ahb_haddr,
    input  logic [2:0]           ahb_hsize,
    input  logic [3:0]           ahb_hprot,
    input  logic [31:0]          ahb_hwdata,
    input  logic                 ahb_hready,
    output logic                 ahb_hreadyout,
    output logic                 ahb_hresp,
    output logic [31:0]          ahb_hrdata,
    output logic                 apb_psel,
    output logic                 apb_penable,
    output logic                 apb_pwrite,
    output logic [ADDR_BITS-1:0] apb_paddr,
    output logic [31:0]          apb_pwdata,
    output logic [3:0]           apb_pstrb,
    output logic [2:0]           apb_pprot,
    input  logic                 apb_pready,
    input  logic                 apb_pslverr,
    input  logic [31:0]          apb_prdata
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        DONE,
        ERR1,
        ERR2
    } state_t;

    state_t     state;
    logic       accept;
    logic [3:0] strb_next;
    logic [2:0] prot_next;
    logic       unused_inputs;

    // A valid AHB address phase aimed at us. This only matters in states that
    // drive hreadyout high.
    assign accept = ahb_hsel && ahb_hready && ahb_htrans[1];

    // These bits are not used. They are reduced here only to mark them as intentionally ignored.
    assign unused_inputs = &{1'b0, ahb_htrans[0], ahb_hprot[3:2]};

    // APB protection is taken from the AHB privilege and data/opcode bits.
    assign prot_next = {~ahb_hprot[0], 1'b1, ahb_hprot[1]};

    // Work out which byte lanes the transfer touches. Reads never drive strobes.
    always_comb begin
        strb_next = 4'b0000;
        if (ahb_hwrite) begin
            case (ahb_hsize)
                3'd0:    strb_next = 4'b0001 << ahb_haddr[1:0];
                3'd1:    strb_next = ahb_haddr[1] ? 4'b1100 : 4'b0011;
                3'd2:    strb_next = 4'b1111;
                default: strb_next = 4'b0000;
            endcase
        end
    end

    // Bridge state machine. All AHB and APB outputs are registered here.
    // The APB address and control signals are loaded only when a good transfer
    // is accepted, so they stay stable through the access and after it.
    always_ff @(posedge ahb_clock) begin
        if (reset) begin
            state         <= IDLE;
            ahb_hreadyout <= 1'b1;
            ahb_hresp     <= 1'b0;
            ahb_hrdata    <= '0;
            apb_psel      <= 1'b0;
            apb_penable   <= 1'b0;
            apb_pwrite    <= 1'b0;
            apb_paddr     <= '0;
            apb_pwdata    <= '0;
            apb_pstrb     <= '0;
            apb_pprot     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR2: begin
                    apb_psel    <= 1'b0;
                    apb_penable <= 1'b0;
                    if (accept) begin
                        ahb_hreadyout <= 1'b0;
                        if (ahb_hsize > 3'd2) begin
                            state     <= ERR1;
                            ahb_hresp <= 1'b1;
                        end else begin
                            state      <= LATCH;
                            ahb_hresp  <= 1'b0;
                            apb_paddr  <= ahb_haddr;
                            apb_pwrite <= ahb_hwrite;
                            apb_pstrb  <= strb_next;
                            apb_pprot  <= prot_next;
                        end
                    end else begin
                        state         <= IDLE;
                        ahb_hreadyout <= 1'b1;
                        ahb_hresp     <= 1'b0;
                    end
                end
                LATCH: begin
                    if (apb_pwrite) begin
                        apb_pwdata <= ahb_hwdata;
                    end
                    state    <= SETUP;
                    apb_psel <= 1'b1;
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb_penable <= 1'b1;
                end
                ACCESS: begin
                    if (apb_pready) begin
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        if (apb_pslverr) begin
                            state     <= ERR1;
                            ahb_hresp <= 1'b1;
                        end else begin
                            state         <= DONE;
                            ahb_hreadyout <= 1'b1;
                            if (!apb_pwrite) begin
                                ahb_hrdata <= apb_prdata;
                            end
                        end
                    end
                end
                ERR1: begin
                    state         <= ERR2;
                    ahb_hreadyout <= 1'b1;
                    ahb_hresp     <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    ahb_hreadyout <= 1'b1;
                    ahb_hresp     <= 1'b0;
                    apb_psel      <= 1'b0;
                    apb_penable   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2apb.sv
// Self-checking bench for ahb2apb. A simple transaction-level model predicts
// the strobes, protection, latencies, error responses and returned read data.
module tb_ahb2apb;

    logic        ahb_clock = 1'b0;
    logic        reset;
    logic        ahb_hsel;
    logic [1:0]  ahb_htrans;
    logic        ahb_hwrite;
    logic [31:0] ahb_haddr;
    logic [2:0]  ahb_hsize;
    logic [3:0]  ahb_hprot;
    logic [31:0] ahb_hwdata;
    logic        ahb_hready;
    logic        ahb_hreadyout;
    logic        ahb_hresp;
    logic [31:0] ahb_hrdata;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_paddr;
    logic [31:0] apb_pwdata;
    logic [3:0]  apb_pstrb;
    logic [2:0]  apb_pprot;
    logic        apb_pready;
    logic        apb_pslverr;
    logic [31:0] apb_prdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: last successfully read data and last data written to APB
    logic [31:0] m_hrdata;
    logic [31:0] m_pwdata;

    // Observations recorded by the transfer driver
    int          obs_low, obs_psel, obs_access, obs_hresp_low, obs_pre_psel;
    logic        obs_unstable, obs_timeout, obs_setup_pen, obs_hresp_end, obs_psel_end;
    logic        obs_pwrite;
    logic [31:0] obs_paddr, obs_pwdata, obs_hrdata_end;
    logic [3:0]  obs_pstrb;
    logic [2:0]  obs_pprot;

    // Free-running clock
    always #5 ahb_clock = ~ahb_clock;

    ahb2apb #(.ADDR_BITS(32)) dut (
        .ahb_clock    (ahb_clock),
        .reset        (reset),
        .ahb_hsel     (ahb_hsel),
        .ahb_htrans   (ahb_htrans),
        .ahb_hwrite   (ahb_hwrite),
        .ahb_haddr    (ahb_haddr),
        .ahb_hsize    (ahb_hsize),
        .ahb_hprot    (ahb_hprot),
        .ahb_hwdata   (ahb_hwdata),
        .ahb_hready   (ahb_hready),
        .ahb_hreadyout(ahb_hreadyout),
        .ahb_hresp    (ahb_hresp),
        .ahb_hrdata   (ahb_hrdata),
        .apb_psel     (apb_psel),
        .apb_penable  (apb_penable),
        .apb_pwrite   (apb_pwrite),
        .apb_paddr    (apb_paddr),
        .apb_pwdata   (apb_pwdata),
        .apb_pstrb    (apb_pstrb),
        .apb_pprot    (apb_pprot),
        .apb_pready   (apb_pready),
        .apb_pslverr  (apb_pslverr),
        .apb_prdata   (apb_prdata)
    );

    // Byte lanes covered by a naturally aligned access of 2**size bytes
    function automatic logic [3:0] exp_strb(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        int nbytes;
        int lane;
        if (!wr || size > 3'd2) return 4'b0000;
        nbytes = 1 << size;
        lane   = (int'(addr[1:0]) / nbytes) * nbytes;
        return 4'(((1 << nbytes) - 1) << lane);
    endfunction

    function automatic logic [2:0] exp_prot(input logic [3:0] prot);
        return 3'((prot[0] ? 0 : 4) + 2 + (prot[1] ? 1 : 0));
    endfunction

    task automatic idle_cycles(input int n);
        ahb_hsel   = 1'b0;
        ahb_htrans = 2'b00;
        ahb_hready = 1'b1;
        repeat (n) begin
            @(posedge ahb_clock); #1;
        end
    endtask

    // Run one AHB transfer and act as an APB slave with a given number of
    // wait states. Entered and left just after a clock edge. On exit the
    // current cycle is the one where hreadyout is high again.
    task automatic do_transfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                               input logic [3:0] prot, input logic [31:0] wdata, input int waits,
                               input logic slverr, input logic [31:0] rdata);
        int   acc;
        logic seen;
        ahb_hsel   = 1'b1;
        ahb_htrans = 2'b10;
        ahb_hwrite = wr;
        ahb_haddr  = addr;
        ahb_hsize  = size;
        ahb_hprot  = prot;
        ahb_hready = 1'b1;
        @(posedge ahb_clock); #1;
        ahb_hsel      = 1'b0;
        ahb_htrans    = 2'b00;
        ahb_haddr     = $urandom;
        ahb_hwdata    = wdata;
        obs_low       = 0;
        obs_psel      = 0;
        obs_access    = 0;
        obs_hresp_low = 0;
        obs_pre_psel  = 0;
        obs_unstable  = 1'b0;
        obs_timeout   = 1'b0;
        obs_setup_pen = 1'b0;
        seen          = 1'b0;
        acc           = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 1) ahb_hwdata = $urandom;
            if (ahb_hreadyout) begin
                obs_hresp_end  = ahb_hresp;
                obs_hrdata_end = ahb_hrdata;
                obs_psel_end   = apb_psel;
                if (seen && ({apb_paddr, apb_pwdata, apb_pstrb, apb_pprot, apb_pwrite} !==
                             {obs_paddr, obs_pwdata, obs_pstrb, obs_pprot, obs_pwrite}))
                    obs_unstable = 1'b1;
                apb_pready  = 1'b0;
                apb_pslverr = 1'b0;
                return;
            end
            obs_low++;
            if (ahb_hresp) obs_hresp_low++;
            apb_pready  = 1'b0;
            apb_pslverr = 1'(($urandom_range(0, 1)));
            apb_prdata  = $urandom;
            if (apb_psel) begin
                obs_psel++;
                if (!seen) begin
                    seen          = 1'b1;
                    obs_setup_pen = apb_penable;
                    obs_paddr     = apb_paddr;
                    obs_pwdata    = apb_pwdata;
                    obs_pstrb     = apb_pstrb;
                    obs_pprot     = apb_pprot;
                    obs_pwrite    = apb_pwrite;
                end else if ({apb_paddr, apb_pwdata, apb_pstrb, apb_pprot, apb_pwrite} !==
                             {obs_paddr, obs_pwdata, obs_pstrb, obs_pprot, obs_pwrite}) begin
                    obs_unstable = 1'b1;
                end
                if (apb_penable) begin
                    acc++;
                    obs_access++;
                    if (acc > waits) begin
                        apb_pready  = 1'b1;
                        apb_pslverr = slverr;
                        apb_prdata  = rdata;
                    end
                end
            end else if (!seen) begin
                obs_pre_psel++;
            end
            @(posedge ahb_clock); #1;
        end
        obs_timeout = 1'b1;
        $display("[TB] FAIL transfer_timeout addr=%h hreadyout stayed 0, required completion within 60 cycles", addr);
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        ahb_hsel    = 1'b0;
        ahb_htrans  = 2'b00;
        ahb_hwrite  = 1'b0;
        ahb_haddr   = '0;
        ahb_hsize   = '0;
        ahb_hprot   = '0;
        ahb_hwdata  = '0;
        ahb_hready  = 1'b1;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        apb_prdata  = '0;
        m_hrdata    = '0;
        m_pwdata    = '0;
        repeat (3) begin
            @(posedge ahb_clock); #1;
        end
        n_checks++;
        if ({ahb_hreadyout, ahb_hresp, apb_psel, apb_penable, apb_pwrite} !== 5'b10000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl got %b required 10000", {ahb_hreadyout, ahb_hresp, apb_psel, apb_penable, apb_pwrite});
        end
        n_checks++;
        if ({ahb_hrdata, apb_paddr, apb_pwdata, apb_pstrb, apb_pprot} !== 103'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data got hrdata=%h paddr=%h pwdata=%h pstrb=%h pprot=%h required all zero",
                     ahb_hrdata, apb_paddr, apb_pwdata, apb_pstrb, apb_pprot);
        end
        reset = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_word_write;
        do_transfer(32'h10, 1'b1, 3'd2, 4'b0011, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        m_pwdata = 32'hDEADBEEF;
        n_checks++;
        if (obs_timeout || obs_low !== 3) begin
            n_fail++; $display("[TB] FAIL ww_latency got %0d hreadyout-low cycles, required 3", obs_low);
        end
        n_checks++;
        if (obs_psel !== 2 || obs_access !== 1 || obs_setup_pen !== 1'b0 || obs_pre_psel !== 1) begin
            n_fail++; $display("[TB] FAIL ww_phases got psel=%0d access=%0d setup_pen=%b pre=%0d required 2 1 0 1",
                               obs_psel, obs_access, obs_setup_pen, obs_pre_psel);
        end
        n_checks++;
        if ({obs_paddr, obs_pstrb, obs_pwdata, obs_pwrite} !== {32'h10, 4'hF, 32'hDEADBEEF, 1'b1}) begin
            n_fail++; $display("[TB] FAIL ww_apb got paddr=%h pstrb=%h pwdata=%h pwrite=%b required 10 f deadbeef 1",
                               obs_paddr, obs_pstrb, obs_pwdata, obs_pwrite);
        end
        n_checks++;
        if (obs_pprot !== exp_prot(4'b0011) || obs_hresp_end !== 1'b0 || obs_unstable) begin
            n_fail++; $display("[TB] FAIL ww_prot_resp got pprot=%b hresp=%b unstable=%b required %b 0 0",
                               obs_pprot, obs_hresp_end, obs_unstable, exp_prot(4'b0011));
        end
        idle_cycles(1);
    endtask

    task automatic test_byte_half;
        do_transfer(32'h13, 1'b1, 3'd0, 4'b0000, 32'h11223344, 0, 1'b0, 32'h0);
        m_pwdata = 32'h11223344;
        n_checks++;
        if (obs_pstrb !== 4'b1000 || obs_pwdata !== m_pwdata) begin
            n_fail++; $display("[TB] FAIL byte_strb got pstrb=%b pwdata=%h required 1000 %h", obs_pstrb, obs_pwdata, m_pwdata);
        end
        idle_cycles(1);
        do_transfer(32'h12, 1'b1, 3'd1, 4'b0001, 32'h55667788, 0, 1'b0, 32'h0);
        m_pwdata = 32'h55667788;
        n_checks++;
        if (obs_pstrb !== 4'b1100 || obs_pprot !== exp_prot(4'b0001)) begin
            n_fail++; $display("[TB] FAIL half_strb got pstrb=%b pprot=%b required 1100 %b", obs_pstrb, obs_pprot, exp_prot(4'b0001));
        end
        idle_cycles(1);
        do_transfer(32'h13, 1'b0, 3'd0, 4'b0000, 32'hFFFFFFFF, 0, 1'b0, 32'hA5A5_0F0F);
        m_hrdata = 32'hA5A5_0F0F;
        n_checks++;
        if (obs_pstrb !== 4'b0000 || obs_pwrite !== 1'b0 || obs_hrdata_end !== m_hrdata || obs_pwdata !== m_pwdata) begin
            n_fail++; $display("[TB] FAIL read_strb got pstrb=%b pwrite=%b hrdata=%h pwdata=%h required 0000 0 %h %h",
                               obs_pstrb, obs_pwrite, obs_hrdata_end, obs_pwdata, m_hrdata, m_pwdata);
        end
        idle_cycles(1);
    endtask

    task automatic test_read_wait;
        do_transfer(32'h80, 1'b0, 3'd2, 4'b0010, 32'h0, 3, 1'b0, 32'h12345678);
        m_hrdata = 32'h12345678;
        n_checks++;
        if (obs_timeout || obs_access !== 4 || obs_low !== 6) begin
            n_fail++; $display("[TB] FAIL rw_waits got access=%0d low=%0d required 4 6", obs_access, obs_low);
        end
        n_checks++;
        if (obs_hrdata_end !== 32'h12345678 || obs_hresp_end !== 1'b0 || obs_unstable) begin
            n_fail++; $display("[TB] FAIL rw_data got hrdata=%h hresp=%b unstable=%b required 12345678 0 0",
                               obs_hrdata_end, obs_hresp_end, obs_unstable);
        end
        idle_cycles(1);
    endtask

    task automatic test_slave_error;
        do_transfer(32'h30, 1'b1, 3'd2, 4'b0000, 32'hCAFEF00D, 1, 1'b1, 32'h0);
        m_pwdata = 32'hCAFEF00D;
        n_checks++;
        if (obs_timeout || obs_hresp_low !== 1 || obs_hresp_end !== 1'b1 || obs_low !== 5) begin
            n_fail++; $display("[TB] FAIL slverr_resp got hresp_low=%0d hresp_end=%b low=%0d required 1 1 5",
                               obs_hresp_low, obs_hresp_end, obs_low);
        end
        n_checks++;
        if (obs_hrdata_end !== m_hrdata) begin
            n_fail++; $display("[TB] FAIL slverr_hrdata got %h required %h", obs_hrdata_end, m_hrdata);
        end
        idle_cycles(1);
        n_checks++;
        if (ahb_hresp !== 1'b0 || ahb_hreadyout !== 1'b1) begin
            n_fail++; $display("[TB] FAIL slverr_release got hresp=%b hreadyout=%b required 0 1", ahb_hresp, ahb_hreadyout);
        end
        do_transfer(32'h34, 1'b1, 3'd3, 4'b0000, 32'h0BAD0BAD, 0, 1'b0, 32'h0);
        n_checks++;
        if (obs_timeout || obs_psel !== 0 || obs_low !== 1 || obs_hresp_low !== 1 || obs_hresp_end !== 1'b1) begin
            n_fail++; $display("[TB] FAIL badsize_resp got psel=%0d low=%0d hresp_low=%0d hresp_end=%b required 0 1 1 1",
                               obs_psel, obs_low, obs_hresp_low, obs_hresp_end);
        end
        idle_cycles(1);
        n_checks++;
        if (apb_pwdata !== m_pwdata || ahb_hresp !== 1'b0) begin
            n_fail++; $display("[TB] FAIL badsize_after got pwdata=%h hresp=%b required %h 0", apb_pwdata, ahb_hresp, m_pwdata);
        end
    endtask

    task automatic test_back_to_back;
        logic done_psel;
        do_transfer(32'h20, 1'b1, 3'd2, 4'b0000, 32'h0F0F0F0F, 0, 1'b0, 32'h0);
        m_pwdata  = 32'h0F0F0F0F;
        done_psel = obs_psel_end;
        n_checks++;
        if (obs_paddr !== 32'h20 || obs_hrdata_end !== m_hrdata) begin
            n_fail++; $display("[TB] FAIL b2b_first got paddr=%h hrdata=%h required 20 %h", obs_paddr, obs_hrdata_end, m_hrdata);
        end
        do_transfer(32'h24, 1'b0, 3'd2, 4'b0000, 32'h0, 0, 1'b0, 32'h87654321);
        m_hrdata = 32'h87654321;
        // Between the two accesses psel drops in the DONE cycle and the LATCH cycle
        n_checks++;
        if (done_psel !== 1'b0 || obs_pre_psel !== 1 || obs_low !== 3) begin
            n_fail++; $display("[TB] FAIL b2b_gap got done_psel=%b pre=%0d low=%0d required 0 1 3", done_psel, obs_pre_psel, obs_low);
        end
        n_checks++;
        if (obs_paddr !== 32'h24 || obs_hrdata_end !== 32'h87654321) begin
            n_fail++; $display("[TB] FAIL b2b_second got paddr=%h hrdata=%h required 24 87654321", obs_paddr, obs_hrdata_end);
        end
        idle_cycles(1);
    endtask

    task automatic test_idle_okay;
        ahb_hsel   = 1'b1;
        ahb_hready = 1'b1;
        ahb_hwrite = 1'b1;
        ahb_haddr  = 32'h50;
        ahb_hsize  = 3'd2;
        for (int k = 0; k < 4; k++) begin
            ahb_hsel   = (k != 2);
            ahb_htrans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
            ahb_hready = (k != 3);
            @(posedge ahb_clock); #1;
            n_checks++;
            if ({ahb_hreadyout, ahb_hresp, apb_psel} !== 3'b100) begin
                n_fail++; $display("[TB] FAIL idle_okay_%0d got hreadyout/hresp/psel=%b required 100",
                                   k, {ahb_hreadyout, ahb_hresp, apb_psel});
            end
        end
        idle_cycles(2);
        n_checks++;
        if (apb_psel !== 1'b0 || ahb_hreadyout !== 1'b1) begin
            n_fail++; $display("[TB] FAIL idle_noaccess got psel=%b hreadyout=%b required 0 1", apb_psel, ahb_hreadyout);
        end
    endtask

    task automatic test_reset_mid;
        ahb_hsel   = 1'b1;
        ahb_htrans = 2'b10;
        ahb_hwrite = 1'b1;
        ahb_haddr  = 32'h40;
        ahb_hsize  = 3'd2;
        ahb_hready = 1'b1;
        apb_pready = 1'b0;
        @(posedge ahb_clock); #1;
        ahb_hsel   = 1'b0;
        ahb_htrans = 2'b00;
        ahb_hwdata = 32'h77777777;
        repeat (2) begin
            @(posedge ahb_clock); #1;
        end
        n_checks++;
        if ({apb_psel, apb_penable} !== 2'b11) begin
            n_fail++; $display("[TB] FAIL rstmid_access got psel/penable=%b required 11", {apb_psel, apb_penable});
        end
        reset = 1'b1;
        @(posedge ahb_clock); #1;
        reset    = 1'b0;
        m_hrdata = '0;
        m_pwdata = '0;
        n_checks++;
        if ({apb_psel, apb_penable, ahb_hreadyout, ahb_hresp} !== 4'b0010 || ahb_hrdata !== 32'h0 || apb_pwdata !== 32'h0) begin
            n_fail++; $display("[TB] FAIL rstmid_state got psel/pen/hready/hresp=%b hrdata=%h pwdata=%h required 0010 0 0",
                               {apb_psel, apb_penable, ahb_hreadyout, ahb_hresp}, ahb_hrdata, apb_pwdata);
        end
        do_transfer(32'h44, 1'b0, 3'd2, 4'b0000, 32'h0, 1, 1'b0, 32'h3C3C3C3C);
        m_hrdata = 32'h3C3C3C3C;
        n_checks++;
        if (obs_timeout || obs_access !== 2 || obs_hrdata_end !== m_hrdata || obs_paddr !== 32'h44) begin
            n_fail++; $display("[TB] FAIL rstmid_next got access=%0d hrdata=%h paddr=%h required 2 %h 44",
                               obs_access, obs_hrdata_end, obs_paddr, m_hrdata);
        end
        idle_cycles(1);
    endtask

    task automatic test_random;
        logic [31:0] addr, wdata, rdata;
        logic        wr, err, good;
        logic [2:0]  size;
        logic [3:0]  prot;
        int          waits, exp_low;
        for (int i = 0; i < 30; i++) begin
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            wr    = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            prot  = 4'($urandom);
            waits = $urandom_range(0, 3);
            err   = ($urandom_range(0, 4) == 0);
            good  = (size <= 3'd2);
            do_transfer(addr, wr, size, prot, wdata, waits, err, rdata);
            if (good && wr) m_pwdata = wdata;
            if (good && !wr && !err) m_hrdata = rdata;
            exp_low = !good ? 1 : (err ? 4 + waits : 3 + waits);
            n_checks++;
            if (obs_timeout || obs_low !== exp_low || obs_psel !== (good ? 2 + waits : 0)) begin
                n_fail++; $display("[TB] FAIL rand_%0d_timing got low=%0d psel=%0d required %0d %0d",
                                   i, obs_low, obs_psel, exp_low, good ? 2 + waits : 0);
            end
            n_checks++;
            if (obs_hresp_end !== (!good || err) || obs_hrdata_end !== m_hrdata) begin
                n_fail++; $display("[TB] FAIL rand_%0d_resp got hresp=%b hrdata=%h required %b %h",
                                   i, obs_hresp_end, obs_hrdata_end, (!good || err), m_hrdata);
            end
            if (good) begin
                n_checks++;
                if ({obs_paddr, obs_pstrb, obs_pwdata, obs_pprot, obs_pwrite, obs_unstable} !==
                    {addr, exp_strb(addr, wr, size), m_pwdata, exp_prot(prot), wr, 1'b0}) begin
                    n_fail++; $display("[TB] FAIL rand_%0d_apb got paddr=%h pstrb=%b pwdata=%h pprot=%b pwrite=%b unstable=%b required %h %b %h %b %b 0",
                                       i, obs_paddr, obs_pstrb, obs_pwdata, obs_pprot, obs_pwrite, obs_unstable,
                                       addr, exp_strb(addr, wr, size), m_pwdata, exp_prot(prot), wr);
                end
            end
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(1);
    endtask

    // Run every scenario in order and print the summary
    initial begin
        test_reset();
        test_word_write();
        test_byte_half();
        test_read_wait();
        test_slave_error();
        test_back_to_back();
        test_idle_okay();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
